// File: rtl/avr_io_gpio_pkg.sv
// avr_io_gpio shared definitions: register address map
// of the GPIO block within its I/O window.
package avr_io_gpio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_PIN   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DDR   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PORT  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PCMSK = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PCIF  = 3'd4;

endpackage

// File: rtl/avr_io_sync.sv
// avr_io_sync: multi-stage synchroniser for asynchronous
// pad inputs, cleared by synchronous reset.
module avr_io_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // shift pad samples one stage per clock
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/avr_io_gpio.sv
// avr_io_gpio: AVR-style PORT/DDR/PIN GPIO with toggle-on-PIN-write.
// Pin-change interrupt (PCMSK/PCIF/irq) built only with AVR_IO_GPIO_PCINT_EN.
module avr_io_gpio
    import avr_io_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] io_a,
    input  logic              io_re,
    input  logic              io_we,
    input  logic [7:0]        io_di,
    output logic [7:0]        io_do,
    input  logic [WIDTH-1:0]  pin_in,
    output logic [WIDTH-1:0]  port_out,
    output logic [WIDTH-1:0]  port_oe,
    output logic              irq
);

    logic [WIDTH-1:0] port_q;
    logic [WIDTH-1:0] ddr_q;
    logic [WIDTH-1:0] pin_s;
    logic [WIDTH-1:0] wd;
    logic             wr_pin;
    logic             wr_ddr;
    logic             wr_port;
    logic [WIDTH-1:0] rd;

    assign wd      = io_di[WIDTH-1:0];
    assign wr_pin  = io_we && (io_a == ADDR_PIN);
    assign wr_ddr  = io_we && (io_a == ADDR_DDR);
    assign wr_port = io_we && (io_a == ADDR_PORT);

    avr_io_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_in),
        .q   (pin_s)
    );

    // output latch and direction; a PIN write toggles PORT bits
    always_ff @(posedge clk) begin
        if (rst) begin
            port_q <= '0;
            ddr_q  <= '0;
        end else begin
            if (wr_ddr) begin
                ddr_q <= wd;
            end
            if (wr_port) begin
                port_q <= wd;
            end else if (wr_pin) begin
                port_q <= port_q ^ wd;
            end
        end
    end

    assign port_out = port_q;
    assign port_oe  = ddr_q;

`ifdef AVR_IO_GPIO_PCINT_EN
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_N = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] pcmsk_q;
    logic [WIDTH-1:0] pcif_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] clr;
    logic [CW-1:0]    arm_cnt;
    logic             armed;
    logic             wr_pcmsk;
    logic             wr_pcif;

    assign wr_pcmsk = io_we && (io_a == ADDR_PCMSK);
    assign wr_pcif  = io_we && (io_a == ADDR_PCIF);
    assign armed    = (arm_cnt == ARM_N);
    assign chg      = (pin_s ^ prev_q) & pcmsk_q & {WIDTH{armed}};
    assign clr      = wr_pcif ? wd : '0;

    // warm-up: ignore edges seen while the chain fills after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + CW'(1);
        end
    end

    // change detect; a new change beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            pcmsk_q <= '0;
            pcif_q  <= '0;
            prev_q  <= '0;
        end else begin
            prev_q <= pin_s;
            pcif_q <= (pcif_q & ~clr) | chg;
            if (wr_pcmsk) begin
                pcmsk_q <= wd;
            end
        end
    end

    assign irq = |pcif_q;
`else
    assign irq = 1'b0;
`endif

    // register read mux, zero for unmapped addresses
    always_comb begin
        rd = '0;
        case (io_a)
            ADDR_PIN:   rd = pin_s;
            ADDR_DDR:   rd = ddr_q;
            ADDR_PORT:  rd = port_q;
`ifdef AVR_IO_GPIO_PCINT_EN
            ADDR_PCMSK: rd = pcmsk_q;
            ADDR_PCIF:  rd = pcif_q;
`endif
            default:    rd = '0;
        endcase
    end

    // zero-extended read bus, idle low
    always_comb begin
        io_do = 8'h00;
        if (io_re) begin
            io_do[WIDTH-1:0] = rd;
        end
    end

endmodule

// File: tb/tb_avr_io_gpio.sv
// tb_avr_io_gpio: randomized and directed checks of an 8-pin and a
// 4-pin instance against a history-based register model.
module tb_avr_io_gpio;

    localparam int S = 2;
`ifdef AVR_IO_GPIO_PCINT_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] io_a = '0;
    logic       io_re = 1'b0;
    logic       io_we = 1'b0;
    logic [7:0] io_di = '0;
    logic [7:0] io_do;
    logic [7:0] pin_in = '0;
    logic [7:0] port_out;
    logic [7:0] port_oe;
    logic       irq;
    logic [7:0] io_do4;
    logic [3:0] pin_in4;
    logic [3:0] port_out4;
    logic [3:0] port_oe4;
    logic       irq4;

    int checks = 0;
    int errors = 0;

    assign pin_in4 = pin_in[3:0];

    avr_io_gpio #(.WIDTH(8), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .io_a(io_a), .io_re(io_re),
        .io_we(io_we), .io_di(io_di), .io_do(io_do),
        .pin_in(pin_in), .port_out(port_out),
        .port_oe(port_oe), .irq(irq)
    );

    avr_io_gpio #(.WIDTH(4), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .rst(rst), .io_a(io_a), .io_re(io_re),
        .io_we(io_we), .io_di(io_di), .io_do(io_do4),
        .pin_in(pin_in4), .port_out(port_out4),
        .port_oe(port_oe4), .irq(irq4)
    );

    always #5 clk = ~clk;

    // model: registers per instance plus the raw pad history since reset
    logic [7:0] m_port[2];
    logic [7:0] m_ddr[2];
    logic [7:0] m_msk[2];
    logic [7:0] m_pcif[2];
    logic [7:0] hist[$];

    function automatic logic [7:0] wmask(int i);
        return (i == 0) ? 8'hFF : 8'h0F;
    endfunction

    // pad value visible on PIN after k edges since reset
    function automatic logic [7:0] pin_at(int k);
        if (k >= S) return hist[k-S];
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_rd(int i, logic [2:0] a);
        case (a)
            3'd0: return pin_at(hist.size()) & wmask(i);
            3'd1: return m_ddr[i];
            3'd2: return m_port[i];
            3'd3: return PC ? m_msk[i] : 8'h00;
            3'd4: return PC ? m_pcif[i] : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_edge();
        int n;
        logic [7:0] chg;
        logic [7:0] d;
        n = hist.size();
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_port[i] = 0; m_ddr[i] = 0;
                m_msk[i] = 0; m_pcif[i] = 0;
            end
            hist.delete();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            d = io_di & wmask(i);
            chg = 8'h00;
            if (PC && (n + 1 >= S + 2))
                chg = (pin_at(n) ^ pin_at(n-1)) & m_msk[i];
            if (io_we) begin
                case (io_a)
                    3'd0: m_port[i] = m_port[i] ^ d;
                    3'd1: m_ddr[i] = d;
                    3'd2: m_port[i] = d;
                    3'd3: if (PC) m_msk[i] = d;
                    3'd4: if (PC) m_pcif[i] = m_pcif[i] & ~d;
                    default: ;
                endcase
            end
            m_pcif[i] = m_pcif[i] | chg;
        end
        hist.push_back(pin_in);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(logic [2:0] a, logic [7:0] d);
        io_we = 1'b1; io_a = a; io_di = d;
        cycle();
        io_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pin_in = 8'hFF;
        repeat (3) cycle();
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            io_re = 1'b1; io_a = 3'(a);
            #1;
            checks++;
            if (io_do !== 8'h00 || io_do4 !== 8'h00) begin
                errors++;
                $display("FAIL reset_rd a=%0d got %h/%h want 00", a, io_do, io_do4);
            end
        end
        io_re = 1'b0;
        checks++;
        if (port_out !== 0 || port_oe !== 0 || irq !== 0) begin
            errors++;
            $display("FAIL reset_out got %h %h %b want 00 00 0", port_out, port_oe, irq);
        end
        wr(3'd3, 8'hFF);
        repeat (S + 4) cycle();
        io_re = 1'b1; io_a = 3'd4;
        #1;
        checks++;
        if (io_do !== 8'h00 || irq !== 1'b0 || irq4 !== 1'b0) begin
            errors++;
            $display("FAIL warmup_pcif got %h irq %b want 00 0", io_do, irq);
        end
        io_a = 3'd0;
        #1;
        checks++;
        if (io_do !== 8'hFF || io_do4 !== 8'h0F) begin
            errors++;
            $display("FAIL pin_ff got %h/%h want ff/0f", io_do, io_do4);
        end
        io_re = 1'b0;
    endtask

    task automatic test_port_ddr();
        wr(3'd1, 8'h0F);
        wr(3'd2, 8'hA5);
        checks++;
        if (port_oe !== 8'h0F || port_out !== 8'hA5) begin
            errors++;
            $display("FAIL port_ddr got oe %h out %h want 0f a5", port_oe, port_out);
        end
        checks++;
        if (port_oe4 !== 4'hF || port_out4 !== 4'h5) begin
            errors++;
            $display("FAIL port_ddr4 got oe %h out %h want f 5", port_oe4, port_out4);
        end
        io_re = 1'b1; io_a = 3'd2;
        #1;
        checks++;
        if (io_do !== 8'hA5) begin
            errors++;
            $display("FAIL rd_port got %h want a5", io_do);
        end
        io_re = 1'b0;
        #1;
        checks++;
        if (io_do !== 8'h00) begin
            errors++;
            $display("FAIL idle_rd got %h want 00", io_do);
        end
        wr(3'd2, 8'hFF);
        io_re = 1'b1;
        #1;
        checks++;
        if (io_do4 !== 8'h0F || io_do !== 8'hFF) begin
            errors++;
            $display("FAIL w4_port got %h/%h want ff/0f", io_do, io_do4);
        end
        io_re = 1'b0;
        wr(3'd2, 8'hA5);
    endtask

    task automatic test_toggle();
        wr(3'd0, 8'h0F);
        checks++;
        if (port_out !== 8'hAA || port_out !== m_port[0]) begin
            errors++;
            $display("FAIL toggle got %h want aa", port_out);
        end
        wr(3'd0, 8'h00);
        checks++;
        if (port_out !== 8'hAA || port_out4 !== 4'hA) begin
            errors++;
            $display("FAIL toggle0 got %h/%h want aa/a", port_out, port_out4);
        end
    endtask

    task automatic test_pcint();
        wr(3'd4, 8'hFF);
        pin_in = 8'h00;
        repeat (S + 2) cycle();
        wr(3'd3, 8'h01);
        wr(3'd4, 8'hFF);
        pin_in = 8'h01;
        repeat (S) cycle();
        io_re = 1'b1; io_a = 3'd0;
        #1;
        checks++;
        if (io_do !== 8'h01 || irq !== 1'b0) begin
            errors++;
            $display("FAIL pc_pin got %h irq %b want 01 0", io_do, irq);
        end
        cycle();
        checks++;
        if (irq !== PC || irq4 !== PC) begin
            errors++;
            $display("FAIL pc_irq got %b/%b want %b", irq, irq4, PC);
        end
        io_a = 3'd4;
        #1;
        checks++;
        if (io_do !== m_rd(0, 3'd4) || io_do !== {7'd0, PC}) begin
            errors++;
            $display("FAIL pc_flag got %h want %h", io_do, m_rd(0, 3'd4));
        end
        io_re = 1'b0;
    endtask

    task automatic test_w1c_collide();
        pin_in = 8'h00;
        repeat (S) cycle();
        wr(3'd4, 8'h01);
        io_re = 1'b1; io_a = 3'd4;
        #1;
        checks++;
        if (io_do !== {7'd0, PC} || irq !== PC) begin
            errors++;
            $display("FAIL collide got %h irq %b want %h", io_do, irq, {7'd0, PC});
        end
        io_re = 1'b0;
        wr(3'd4, 8'h01);
        io_re = 1'b1;
        #1;
        checks++;
        if (io_do !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c got %h irq %b want 00 0", io_do, irq);
        end
        io_re = 1'b0;
        wr(3'd3, 8'h00);
        pin_in = 8'hFF;
        repeat (S + 3) cycle();
        checks++;
        if (irq !== 1'b0 || m_pcif[0] !== 8'h00) begin
            errors++;
            $display("FAIL nomask got irq %b want 0", irq);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            io_we = 1'($urandom_range(0, 1));
            io_re = 1'($urandom_range(0, 1));
            io_a = 3'($urandom_range(0, 7));
            io_di = 8'($urandom);
            if ($urandom_range(0, 2) == 0)
                pin_in = pin_in ^ 8'(1 << $urandom_range(0, 7));
            #1;
            checks++;
            if (io_do !== (io_re ? m_rd(0, io_a) : 8'h00) ||
                io_do4 !== (io_re ? m_rd(1, io_a) : 8'h00)) begin
                errors++;
                $display("FAIL rnd_rd c=%0d a=%0d got %h/%h want %h/%h", c, io_a,
                         io_do, io_do4, io_re ? m_rd(0, io_a) : 8'h00,
                         io_re ? m_rd(1, io_a) : 8'h00);
            end
            cycle();
            checks++;
            if (port_out !== m_port[0] || port_oe !== m_ddr[0] ||
                irq !== (|m_pcif[0]) || port_out4 !== m_port[1][3:0] ||
                port_oe4 !== m_ddr[1][3:0] || irq4 !== (|m_pcif[1])) begin
                errors++;
                $display("FAIL rnd_out c=%0d got %h %h %b want %h %h %b", c,
                         port_out, port_oe, irq, m_port[0], m_ddr[0], |m_pcif[0]);
            end
        end
        rst = 1'b0; io_we = 1'b0; io_re = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_port[i] = 0; m_ddr[i] = 0;
            m_msk[i] = 0; m_pcif[i] = 0;
        end
        test_reset();
        test_port_ddr();
        test_toggle();
        test_pcint();
        test_w1c_collide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avr_io_gpio.md
Name: avr_io_gpio

Overview:
- Parametrised bidirectional GPIO port for the open-avr I/O space; next generation of the single output-latch port.
- Provides AVR-style PORT/DDR/PIN registers, input synchronisation, toggle-by-PIN-write, and a pin-change interrupt flag with per-bit mask.
- Sits on the core's I/O bus and drives chip-level pads through separate out/oe signals; the pad tri-state lives outside.

Parameters:
- WIDTH, 8, number of pins (1..8); io_di/io_do bits above WIDTH-1 are ignored/read 0.
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- io_a  in  3  register select within the block
- io_re  in  1  read strobe
- io_we  in  1  write strobe
- io_di  in  8  write data
- io_do  out  8  read data; 8'h00 when io_re=0
- pin_in  in  WIDTH  asynchronous pad inputs
- port_out  out  WIDTH  pad output values (=PORT)
- port_oe  out  WIDTH  pad output enables (=DDR)
- irq  out  1  pin-change interrupt request, level

Behaviour:
- One clock; reset is synchronous and active-high.
- Address map: 0 PIN, 1 DDR, 2 PORT, 3 PCMSK, 4 PCIF; 5..7 read 0, writes ignored.
- Reset: PORT, DDR, PCMSK, PCIF, sync chain, prev sample = 0; port_out=0, port_oe=0, irq=0; io_do follows io_re combinationally (0 while idle).
- Reads combinational, zero-extended: PIN returns last sync stage; others return register value.
- Writes take effect at the clock edge with io_we=1: DDR<=io_di, PORT<=io_di, PCMSK<=io_di; PIN write: PORT<=PORT^io_di (toggle); PCIF write: write-1-to-clear.
- Synchroniser: pin_in shifted each clock through SYNC_STAGES flops; a change sampled at edge 1 is readable on PIN after edge SYNC_STAGES.
- Change detect: prev <= last stage each clock; chg = (last ^ prev) & PCMSK & {WIDTH{armed}}; PCIF <= PCIF | chg; PCIF set after edge SYNC_STAGES+1; irq = |PCIF.
- Arming: a warm-up counter after reset; armed=0 until SYNC_STAGES+1 edges after rst deasserts, so chain fill never sets PCIF.
- Simultaneous PCIF W1C and new change on same bit: set wins (flag stays 1).
- PCMSK clear does not clear pending PCIF bits.
- rst mid-operation: all state cleared on that edge, warm-up restarts.
- PIN reflects pad regardless of DDR (output pins read back).

Optional Feature:
- Macro AVR_IO_GPIO_PCINT_EN.
- Defined: PCMSK, PCIF, arming counter, irq as above.
- Undefined: addresses 3/4 read 0, writes ignored; irq tied 0; no detect/arming logic; PIN/DDR/PORT unchanged.

Decomposition:
- Package avr_io_gpio_pkg: address constants (ADDR_PIN=0, ADDR_DDR=1, ADDR_PORT=2, ADDR_PCMSK=3, ADDR_PCIF=4), address width 3.
- Sub-module avr_io_sync: WIDTH x SYNC_STAGES synchroniser with synchronous reset, instanced once.

Test Plan:
- Reset then io_re at each address -> all read 8'h00; port_out=0, port_oe=0, irq=0; pin_in=8'hFF held through reset -> PCIF stays 0 after warm-up.
- Write DDR=8'h0F, PORT=8'hA5 -> port_oe=8'h0F, port_out=8'hA5 next cycle; read PORT=8'hA5; io_re=0 -> io_do=0.
- PORT=8'hA5, write PIN=8'h0F -> PORT=8'hAA; PIN write 8'h00 -> no change.
- pin_in 8'h00->8'h01 at edge 1 -> PIN reads 8'h01 after edge 2, irq after edge 3 with PCMSK=8'h01; PCMSK=0 -> PCIF stays 0.
- PCIF=8'h01, W1C 8'h01 same cycle as new change on bit 0 -> PCIF stays 8'h01; W1C with no change -> 8'h00, irq=0.
- WIDTH=4 build: write PORT 8'hFF -> read 8'h0F; macro undefined: write PCMSK 8'hFF, toggle pins -> reads 0, irq=0.
